// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the registered ALU-control stage:
//   - opcode constants used by the decoder
//   - ALU control code constants
//   - FSM state encoding for the output/handshake controller
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // Top-6-bit opcode values recognised by the decoder
    localparam logic [5:0] OPC_RTYPE     = 6'b000000;
    localparam logic [5:0] OPC_ADDI      = 6'b001000;
    localparam logic [5:0] OPC_ORI       = 6'b001001;
    // opc6[5:4] == 2'b01 selects the subtract class
    localparam logic [1:0] OPC_CLASS_SUB = 2'b01;

    // ALU control codes (4-bit base encoding, zero-extended when wider)
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_VALID = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Pure combinational opcode/funct -> ALU control code decoder, plus the
// multi-cycle classification of the resulting code.
// Ports:
//   opcode  in  OP_W   instruction opcode (rules use the top 6 bits)
//   funcode in  FN_W   instruction funct field (low ALU_W bits used for R-type)
//   code    out ALU_W  decoded ALU control code
//   is_mc   out 1      code is marked multi-cycle and stretching is enabled
// ---------------------------------------------------------------------------
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int                        OP_W    = 6,
    parameter int                        FN_W    = 6,
    parameter int                        ALU_W   = 4,
    parameter logic [(1 << ALU_W)-1:0]   MC_MASK = '0,
    parameter int                        MC_LAT  = 4
) (
    input  logic [OP_W-1:0]  opcode,
    input  logic [FN_W-1:0]  funcode,
    output logic [ALU_W-1:0] code,
    output logic             is_mc
);

    logic [5:0] opc6;
    // Only the top opcode bits and low funct bits participate in decode.
    logic       unused_bits;

    assign opc6        = opcode[OP_W-1 -: 6];
    assign unused_bits = ^{opcode, funcode};

    // Priority-ordered decode; the load/store check on opc6[5] wins over all.
    always_comb begin
        code = '0;
        if (opc6[5]) begin
            code = ALU_W'(ALU_ADD);
        end else if (opc6 == OPC_RTYPE) begin
            code = funcode[ALU_W-1:0];
        end else if ((opc6 == OPC_ADDI) || (opc6[5:4] == OPC_CLASS_SUB)) begin
            code = ALU_W'(ALU_SUB);
        end else if (opc6 == OPC_ORI) begin
            code = ALU_W'(ALU_OR);
        end else begin
            code = ALU_W'(ALU_ADD);
        end
    end

    // A latency below 2 degenerates to single-cycle behaviour.
    assign is_mc = (MC_LAT >= 2) && MC_MASK[code];

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pipe
// Registered, valid/ready handshaked ALU-control stage between decode/RF-read
// and execute. Holds one decoded code; multi-cycle codes are stretched for
// MC_LAT-1 extra... cycles in total MC_LAT-1 edges after accept before valid.
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      upstream presents an instruction
//   in_ready  out 1      stage accepts this cycle (combinational)
//   opcode    in  OP_W   instruction opcode
//   funcode   in  FN_W   instruction funct field
//   flush     in  1      synchronous kill of the held/in-flight entry
//   out_valid out 1      alucode valid to execute stage
//   out_ready in  1      execute stage consumes
//   alucode   out ALU_W  registered ALU control code
//   out_mc    out 1      held code is multi-cycle
//   busy      out 1      multi-cycle countdown in progress
// ---------------------------------------------------------------------------
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int                        OP_W    = 6,
    parameter int                        FN_W    = 6,
    parameter int                        ALU_W   = 4,
    parameter logic [(1 << ALU_W)-1:0]   MC_MASK = '0,
    parameter int                        MC_LAT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [FN_W-1:0]  funcode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALU_W-1:0] alucode,
    output logic             out_mc,
    output logic             busy
);

    localparam int             CNT_W    = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    // Countdown preload: BUSY lasts MC_LAT-1 cycles, leaving on counter==0.
    localparam logic [CNT_W-1:0] CNT_LOAD = (MC_LAT >= 2) ? CNT_W'(MC_LAT - 2) : '0;

    logic [ALU_W-1:0] dec_code;
    logic             dec_mc;
    logic             accept;

    state_t           state_p1, state_nx;
    logic [ALU_W-1:0] code_p1,  code_nx;
    logic             mc_p1,    mc_nx;
    logic [CNT_W-1:0] cnt_p1,   cnt_nx;
    logic             vld_p1;
    logic             busy_p1;

    alu_ctrl_decode #(
        .OP_W    (OP_W),
        .FN_W    (FN_W),
        .ALU_W   (ALU_W),
        .MC_MASK (MC_MASK),
        .MC_LAT  (MC_LAT)
    ) u_decode (
        .opcode  (opcode),
        .funcode (funcode),
        .code    (dec_code),
        .is_mc   (dec_mc)
    );

    // ---- stage p0: handshake and next-state decision ----
    always_comb begin
        in_ready = ~flush & ((state_p1 == ST_IDLE) |
                             ((state_p1 == ST_VALID) & out_ready));
        accept   = in_valid & in_ready;

        state_nx = state_p1;
        code_nx  = code_p1;
        mc_nx    = mc_p1;
        cnt_nx   = cnt_p1;

        if (flush) begin
            // alucode is left untouched; it is meaningless once invalid.
            state_nx = ST_IDLE;
            mc_nx    = 1'b0;
            cnt_nx   = '0;
        end else if (accept) begin
            // Covers both the IDLE capture and the back-to-back VALID refill.
            code_nx = dec_code;
            if (dec_mc) begin
                state_nx = ST_BUSY;
                cnt_nx   = CNT_LOAD;
                mc_nx    = 1'b1;
            end else begin
                state_nx = ST_VALID;
                cnt_nx   = '0;
                mc_nx    = 1'b0;
            end
        end else begin
            case (state_p1)
                ST_IDLE: begin
                end
                ST_BUSY: begin
                    if (cnt_p1 == '0) begin
                        state_nx = ST_VALID;
                    end else begin
                        cnt_nx = cnt_p1 - CNT_W'(1);
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        state_nx = ST_IDLE;
                        mc_nx    = 1'b0;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    mc_nx    = 1'b0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // ---- stage p1: registered state and outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= ST_IDLE;
            code_p1  <= '0;
            mc_p1    <= 1'b0;
            cnt_p1   <= '0;
            vld_p1   <= 1'b0;
            busy_p1  <= 1'b0;
        end else begin
            state_p1 <= state_nx;
            code_p1  <= code_nx;
            mc_p1    <= mc_nx;
            cnt_p1   <= cnt_nx;
            // Dedicated flops keep out_valid/busy glitch-free.
            vld_p1   <= (state_nx == ST_VALID);
            busy_p1  <= (state_nx == ST_BUSY);
        end
    end

    assign out_valid = vld_p1;
    assign busy      = busy_p1;
    assign alucode   = code_p1;
    assign out_mc    = mc_p1;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

    localparam int          OP_W    = 6;
    localparam int          FN_W    = 6;
    localparam int          ALU_W   = 4;
    localparam int          MC_LAT  = 4;
    localparam logic [15:0] MC_MASK = 16'h0100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funcode = '0;
    logic       in_ready;
    logic       out_valid;
    logic       out_mc;
    logic       busy;
    logic [3:0] alucode;

    int tests = 0;
    int fails = 0;

    // Behavioural model: at most one held entry, visible from edge ready_at on.
    bit         m_have = 0;
    int         m_ready_at = 0;
    logic [3:0] m_code = '0;
    bit         m_mc = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    alu_ctrl_pipe #(
        .OP_W    (OP_W),
        .FN_W    (FN_W),
        .ALU_W   (ALU_W),
        .MC_MASK (MC_MASK),
        .MC_LAT  (MC_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funcode   (funcode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alucode   (alucode),
        .out_mc    (out_mc),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [5:0] opc, input logic [5:0] fn);
        logic [3:0] c;
        if (opc[5])                                  c = 4'd0;
        else if (opc == 6'd0)                        c = fn[3:0];
        else if (opc == 6'd8 || opc[5:4] == 2'b01)   c = 4'd1;
        else if (opc == 6'd9)                        c = 4'd5;
        else                                         c = 4'd0;
        return {MC_MASK[c], c};
    endfunction

    task automatic check_outputs();
        bit mv, mb;
        mv = m_have && (cyc >= m_ready_at);
        mb = m_have && (cyc <  m_ready_at);
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("busy",      32'(busy),      32'(mb));
        if (m_have) begin
            chk("alucode", 32'(alucode), 32'(m_code));
            chk("out_mc",  32'(out_mc),  32'(m_mc));
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check in_ready,
    // then advance the model across the rising edge.
    task automatic step(input bit iv, input logic [5:0] opc, input logic [5:0] fn,
                        input bit ordy, input bit fl);
        bit mv, exp_rdy;
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        opcode    = opc;
        funcode   = fn;
        out_ready = ordy;
        flush     = fl;
        #1;
        mv      = m_have && (cyc >= m_ready_at);
        exp_rdy = !fl && (!m_have || (mv && ordy));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        cyc++;
        if (fl) begin
            m_have = 0;
            m_mc   = 0;
        end else if (iv && exp_rdy) begin
            {m_mc, m_code} = ref_decode(opc, fn);
            m_have     = 1;
            m_ready_at = m_mc ? cyc + MC_LAT - 1 : cyc;
        end else if (mv && ordy) begin
            m_have = 0;
        end
    endtask

    initial begin
        logic [5:0] opc_tab [5];
        opc_tab[0] = 6'b000000;
        opc_tab[1] = 6'b001000;
        opc_tab[2] = 6'b001001;
        opc_tab[3] = 6'b100011;
        opc_tab[4] = 6'b011010;

        // Reset state
        #12;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst busy",      32'(busy),      0);
        chk("rst alucode",   32'(alucode),   0);
        chk("rst out_mc",    32'(out_mc),    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load/store decodes to add, single-cycle
        step(1, 6'b100011, 6'b111111, 0, 0);
        #1;
        chk("ls out_valid", 32'(out_valid), 1);
        chk("ls alucode",   32'(alucode),   0);
        chk("ls out_mc",    32'(out_mc),    0);
        step(0, 6'd0, 6'd0, 1, 0);

        // Back-to-back R-type, no bubbles
        for (int i = 0; i < 3; i++) begin
            step(1, 6'b000000, 6'b000110, 1, 0);
            #1;
            chk("rtype out_valid", 32'(out_valid), 1);
            chk("rtype alucode",   32'(alucode),   6);
        end
        step(1, 6'b001001, 6'd0, 1, 0);
        #1 chk("ori alucode", 32'(alucode), 5);
        step(1, 6'b011010, 6'd0, 1, 0);
        #1 chk("subclass alucode", 32'(alucode), 1);
        step(0, 6'd0, 6'd0, 1, 0);
        #1 chk("drain out_valid", 32'(out_valid), 0);

        // Multi-cycle code 8: busy for 3 cycles, then valid and held
        step(1, 6'b000000, 6'b001000, 0, 0);
        #1 chk("mc busy0", 32'(busy), 1);
        step(1, 6'b100011, 6'd0, 0, 0);
        #1 chk("mc busy1", 32'(busy), 1);
        step(1, 6'b001001, 6'd0, 0, 0);
        #1 chk("mc busy2", 32'(busy), 1);
        step(0, 6'd0, 6'd0, 0, 0);
        #1;
        chk("mc out_valid", 32'(out_valid), 1);
        chk("mc alucode",   32'(alucode),   8);
        chk("mc out_mc",    32'(out_mc),    1);
        chk("mc busy_off",  32'(busy),      0);

        // Stall: out_ready low, inputs toggling, nothing captured
        for (int i = 0; i < 5; i++) begin
            step(bit'(i & 1), opc_tab[i], 6'(i), 0, 0);
            #1 chk("stall alucode", 32'(alucode), 8);
        end
        step(0, 6'd0, 6'd0, 1, 0);
        #1 chk("release out_valid", 32'(out_valid), 0);

        // Flush in BUSY, with a concurrent in_valid
        step(1, 6'b000000, 6'b001000, 0, 0);
        step(1, 6'b000000, 6'b000110, 0, 1);
        #1;
        chk("flushB out_valid", 32'(out_valid), 0);
        chk("flushB busy",      32'(busy),      0);
        // Flush in VALID
        step(1, 6'b000000, 6'b000110, 1, 0);
        step(1, 6'b000000, 6'b000011, 1, 1);
        #1;
        chk("flushV out_valid", 32'(out_valid), 0);
        chk("flushV busy",      32'(busy),      0);
        step(0, 6'd0, 6'd0, 1, 0);

        // Asynchronous reset mid-BUSY
        step(1, 6'b000000, 6'b001000, 0, 0);
        step(0, 6'd0, 6'd0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 0);
        chk("arst busy",      32'(busy),      0);
        chk("arst alucode",   32'(alucode),   0);
        m_have = 0;
        m_mc   = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1, 6'b001001, 6'd0, 1, 0);
        #1;
        chk("post-rst out_valid", 32'(out_valid), 1);
        chk("post-rst alucode",   32'(alucode),   5);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [5:0] o;
            o = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                           : opc_tab[$urandom_range(0, 4)];
            step(bit'($urandom_range(0, 3) != 0), o, 6'($urandom_range(0, 63)),
                 bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
        end
        step(0, 6'd0, 6'd0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Registered, handshaked successor of the combinational ALU-control decoder.
- Sits between the decode/register-read stage and the execute stage of the RISC datapath.
- Maps opcode/funct to an ALU control code, holds it in a one-entry output register, and stretches multi-cycle codes (mul/div class) by a programmable number of cycles before presenting them.
- Widths, multi-cycle code set and latency are parametrised.

Parameters:
- OP_W, 6, opcode width (must be >= 6; decode rules below apply to the top 6 bits, opc6 = opcode[OP_W-1:OP_W-6]).
- FN_W, 6, funct-code width (>= ALU_W).
- ALU_W, 4, ALU control code width.
- MC_MASK, 16'h0000, one bit per ALU code (2**ALU_W bits); bit k=1 marks code k as multi-cycle.
- MC_LAT, 4, total cycles a multi-cycle code occupies before out_valid (>= 2; values < 2 treated as 1, i.e. single-cycle).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle.
- opcode  in  OP_W  instruction opcode.
- funcode  in  FN_W  instruction funct field.
- flush  in  1  synchronous kill of held/in-flight entry.
- out_valid  out  1  alucode valid to execute stage.
- out_ready  in  1  execute stage consumes.
- alucode  out  ALU_W  registered ALU control code.
- out_mc  out  1  held code is multi-cycle.
- busy  out  1  multi-cycle countdown in progress.

Behaviour:
- Decode (combinational, priority order):
  1. opc6[5]==1 -> 0 (load/store add).
  2. opc6==6'b000000 -> funcode[ALU_W-1:0].
  3. opc6==6'b001000 or opc6[5:4]==2'b01 -> 1.
  4. opc6==6'b001001 -> 5.
  5. Otherwise -> 0.
  - Code zero-extended to ALU_W if ALU_W > 4.
- Reset (async, rst_n=0): state IDLE, out_valid=0, alucode=0, out_mc=0, busy=0, counter=0.
- FSM states: IDLE, BUSY, VALID.
  - IDLE: in_ready=1. On in_valid, capture decoded code into alucode. If MC_MASK[code]=1 and MC_LAT>=2, go to BUSY with counter=MC_LAT-2, out_mc=1. Else go to VALID, out_mc=0.
  - BUSY: in_ready=0, busy=1, out_valid=0. Counter decrements each cycle; at counter==0 go to VALID.
  - VALID: out_valid=1. If out_ready=1: on in_valid, capture a new code (same rules as IDLE, back-to-back, no bubble); otherwise go to IDLE. If out_ready=0: hold alucode/out_mc stable, in_ready=0.
  - in_ready = (state==IDLE) | (state==VALID & out_ready). Combinational path from out_ready to in_ready is permitted.
- Latency:
  - Single-cycle code: accept at edge N -> out_valid high after edge N.
  - Multi-cycle code: out_valid high after edge N+MC_LAT-1.
- flush (sync, highest priority over all transitions): next state IDLE, out_valid=0, busy=0, out_mc=0, counter=0. alucode retains its value (don't-care). An in_valid in the flush cycle is not accepted: in_ready is forced to 0 while flush=1.
- A deasserted rst_n mid-BUSY aborts immediately. No output glitch on deassert; first accept occurs on the first edge after release.
- All outputs are registered except in_ready.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode constants OPC_RTYPE=6'b000000, OPC_ADDI=6'b001000, OPC_ORI=6'b001001 (class mask 2'b01 on [5:4]);
  - ALU code constants ALU_ADD=0, ALU_SUB=1, ALU_OR=5;
  - FSM state enum (2 bits).
- Sub-module alu_ctrl_decode: pure combinational decode (opcode, funcode -> code, is_mc); instantiated once.

Test Plan:
- Reset then opcode=6'b100011, in_valid=1 for one cycle -> next cycle out_valid=1, alucode=0, out_mc=0; in_ready=1 in IDLE.
- R-type opcode=0, funcode=6'b000110, out_ready=1 held, three back-to-back in_valid -> alucode=6 every cycle, no bubbles. Opcode 6'b001001 -> 5; opcode 6'b011010 -> 1.
- MC_MASK=16'h0100, MC_LAT=4, R-type funcode=6'b001000 -> busy=1 for 3 cycles, in_ready=0, out_valid asserts 3 cycles after accept, alucode=8, out_mc=1.
- VALID with out_ready=0 for 5 cycles, opcode/in_valid toggling -> alucode stable, in_ready=0, no capture; out_ready=1 then releases.
- flush asserted in BUSY and in VALID -> next cycle IDLE, out_valid=0, busy=0; concurrent in_valid not accepted.
- rst_n pulsed low asynchronously mid-BUSY (between edges) -> out_valid/busy/alucode 0 immediately; normal single-cycle decode after release.
